// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer
// Runs TLBP/TLBR/TLBWI/TLBWR against the shared TLB array, stalls the memory
// stage while busy, returns probe/read results to CP0 and owns CP0 Random.
module tlb_op_sequencer #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  output logic              req_ready,
  output logic              stall,
  input  logic              flush,
  input  logic [31:0]       cp0_index,
  input  logic [31:0]       cp0_entry_hi,
  input  logic [31:0]       cp0_entry_lo0,
  input  logic [31:0]       cp0_entry_lo1,
  input  logic [31:0]       cp0_wired,
  input  logic              wired_we,
  output logic [18:0]       srch_vpn2,
  output logic [7:0]        srch_asid,
  input  logic              srch_hit,
  input  logic [IDX_W-1:0]  srch_idx,
  output logic [IDX_W-1:0]  tlb_rd_idx,
  input  logic [95:0]       tlb_rd_data,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_wr_idx,
  output logic [95:0]       tlb_wr_data,
  output logic              resp_valid,
  output logic [1:0]        resp_type,
  output logic [31:0]       resp_index,
  output logic [31:0]       resp_entry_hi,
  output logic [31:0]       resp_lo0,
  output logic [31:0]       resp_lo1,
  output logic              done,
  output logic [31:0]       random
);

  localparam logic [1:0] TLBP  = 2'd0;
  localparam logic [1:0] TLBR  = 2'd1;
  localparam logic [1:0] TLBWR = 2'd3;
  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, OP, RESP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       opCode_q;
  logic [31:0]      entryHi_q, entryLo0_q, entryLo1_q;
  logic [IDX_W-1:0] index_q, wrRandom_q, random_q;
  logic [31:0]      respIndex_q, respEntryHi_q, respLo0_q, respLo1_q;

  logic        accept;
  logic        isWrite;
  logic        loadProbe, loadRead;
  logic        randomReload;
  logic [31:0] randomExt;
  logic [31:0] probeIndex;
  logic        unusedIndexBits;

  assign unusedIndexBits = ^cp0_index[31:IDX_W];

  assign accept     = req_valid && req_ready && !flush;
  assign isWrite    = opCode_q[1];
  assign randomExt  = {{(32-IDX_W){1'b0}}, random_q};
  assign random     = randomExt;
  assign probeIndex = srch_hit ? {{(32-IDX_W){1'b0}}, srch_idx} : 32'h8000_0000;

  // Next-state and strobe decode; strobes are masked during reset so an aborted op emits nothing
  always_comb begin
    state_d     = state_q;
    req_ready   = (state_q == IDLE);
    tlb_we      = 1'b0;
    resp_valid  = 1'b0;
    resp_type   = 2'd0;
    done        = 1'b0;
    srch_vpn2   = entryHi_q[31:13];
    srch_asid   = entryHi_q[7:0];
    tlb_rd_idx  = index_q;
    tlb_wr_idx  = (opCode_q == TLBWR) ? wrRandom_q : index_q;
    tlb_wr_data = {entryHi_q, entryLo0_q, entryLo1_q};
    case (state_q)
      IDLE: begin
        if (accept) state_d = OP;
      end
      OP: begin
        if (isWrite) begin
          tlb_we  = !flush && !reset;
          done    = !reset;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = !flush && !reset;
        done       = !reset;
        if (resp_valid) resp_type = (opCode_q == TLBP) ? 2'd1 : 2'd2;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall = req_valid && !done;
  end

  assign loadProbe = resp_valid && (opCode_q == TLBP);
  assign loadRead  = resp_valid && (opCode_q == TLBR);

  assign resp_index    = loadProbe ? probeIndex          : respIndex_q;
  assign resp_entry_hi = loadRead  ? tlb_rd_data[95:64]  : respEntryHi_q;
  assign resp_lo0      = loadRead  ? tlb_rd_data[63:32]  : respLo0_q;
  assign resp_lo1      = loadRead  ? tlb_rd_data[31:0]   : respLo1_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture at accept so later CP0 writes cannot disturb the in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      opCode_q   <= 2'd0;
      entryHi_q  <= 32'd0;
      entryLo0_q <= 32'd0;
      entryLo1_q <= 32'd0;
      index_q    <= '0;
      wrRandom_q <= '0;
    end else if (accept) begin
      opCode_q   <= req_op;
      entryHi_q  <= cp0_entry_hi;
      entryLo0_q <= cp0_entry_lo0;
      entryLo1_q <= cp0_entry_lo1;
      index_q    <= cp0_index[IDX_W-1:0];
      wrRandom_q <= random_q;
    end
  end

  // Response data holds its last delivered value between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      respIndex_q   <= 32'd0;
      respEntryHi_q <= 32'd0;
      respLo0_q     <= 32'd0;
      respLo1_q     <= 32'd0;
    end else begin
      if (loadProbe) respIndex_q <= probeIndex;
      if (loadRead) begin
        respEntryHi_q <= tlb_rd_data[95:64];
        respLo0_q     <= tlb_rd_data[63:32];
        respLo1_q     <= tlb_rd_data[31:0];
      end
    end
  end

  assign randomReload = wired_we || (cp0_wired >= 32'(TLB_ENTRIES - 1)) ||
                        (randomExt == cp0_wired) || (random_q == '0);

  // Random counts down from the top entry to Wired, then wraps back to the top
  always_ff @(posedge clk) begin
    if (reset)             random_q <= RAND_MAX;
    else if (randomReload) random_q <= RAND_MAX;
    else                   random_q <= random_q - 1'b1;
  end

endmodule

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

Multi-cycle controller that executes TLBP/TLBR/TLBWI/TLBWR for the pipeline against the shared TLB array and returns results to CP0. It stalls the requesting stage while busy, sequences the array's search, read and write ports, and owns the CP0 Random register. It sits between the memory-stage TLB-instruction decode, the TLB array and CP0, whose TLBP/TLBR update path it drives.

## Interface
- TLB_ENTRIES, 16, number of TLB entries (power of two, ≥4)
- IDX_W, $clog2(TLB_ENTRIES), index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  TLB instruction present in stage
- req_op  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
- req_ready  out  1  high only in IDLE; accept = req_valid&&req_ready
- stall  out  1  req_valid && !(done)
- flush  in  1  exception/eret kill of the in-flight instruction
- cp0_index, cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1  in  32 each  current CP0 values
- cp0_wired  in  32  CP0 Wired; wired_we in 1  pulse when Wired is written
- srch_vpn2  out  19, srch_asid  out  8  search key
- srch_hit  in  1, srch_idx  in  IDX_W  registered search result, valid the cycle after key
- tlb_rd_idx  out  IDX_W; tlb_rd_data  in  96  {entry_hi,lo0,lo1}, valid the cycle after address
- tlb_we  out  1; tlb_wr_idx  out  IDX_W; tlb_wr_data  out  96
- resp_valid  out  1  one-cycle CP0 update strobe
- resp_type  out  2  1=TLBP (update Index), 2=TLBR (update EntryHi/Lo0/Lo1), 0 otherwise
- resp_index, resp_entry_hi, resp_lo0, resp_lo1  out  32 each
- done  out  1  one-cycle completion pulse
- random  out  32  CP0 Random, upper bits zero

## Operation
- States: IDLE, OP, RESP.
- IDLE: on accept, capture op, cp0_entry_hi, lo0, lo1, cp0_index[IDX_W-1:0], random[IDX_W-1:0] into operand registers; -> OP. No accept while flush high.
- OP: TLBP drives srch_vpn2=ehi[31:13], srch_asid=ehi[7:0]. TLBR drives tlb_rd_idx=captured index. TLBWI/TLBWR pulse tlb_we=!flush with tlb_wr_idx=captured index/captured random, tlb_wr_data={ehi,lo0,lo1}; writes assert done in OP and -> IDLE. Reads/probes -> RESP.
- RESP: TLBP: resp_index = hit ? zero-extended srch_idx : 32'h8000_0000. TLBR: resp_entry_hi/lo0/lo1 = tlb_rd_data slices [95:64]/[63:32]/[31:0]. resp_valid=!flush, done=1; -> IDLE.
- flush in OP or RESP: suppress tlb_we/resp_valid, still pulse done, return IDLE normally.
- Random: reset TLB_ENTRIES-1; each cycle if random==cp0_wired or random==0 load TLB_ENTRIES-1, else decrement. wired_we forces TLB_ENTRIES-1 next cycle (priority over decrement). If cp0_wired ≥ TLB_ENTRIES-1, random holds TLB_ENTRIES-1.
- resp_* data outputs hold last value when resp_valid low; undefined-value use forbidden.

## Timing
- Reset: state IDLE, req_ready=1, stall=0, tlb_we=0, resp_valid=0, resp_type=0, done=0, resp_* data=0, random=TLB_ENTRIES-1. Reset mid-op aborts with no strobes.
- Accept cycle T. Writes: tlb_we and done at T+1, req_ready at T+2. TLBP/TLBR: key/address at T+1, resp_valid+done at T+2, req_ready at T+3.
- stall high from T while not done; drops in the done cycle so the stage advances next edge.
- Back-to-back: a new op may be accepted the cycle after done.
- CP0 values are sampled only at accept; later CP0 writes do not affect the in-flight op.
- TLBWR index is random at T, not at T+1.

## Test plan
- TLBP hit: entry 5 holds vpn2=0x12345, asid 0x3; accept TLBP with ehi=0x2468_A003 -> resp_valid at T+2, resp_type=1, resp_index=0x0000_0005.
- TLBP miss: empty TLB -> resp_index=0x8000_0000 at T+2, done at T+2.
- TLBR: cp0_index=7, entry 7 = {0xAAAA_A000,0x11,0x22} -> resp_type=2 with those three words at T+2.
- TLBWI then TLBWR: cp0_index=3 -> tlb_we at T+1 to index 3; TLBWR with wired=4 after reset -> writes index equal to sampled random, which cycles 15..4 then back to 15.
- wired_we pulse with random=9 -> random=15 next cycle; cp0_wired=15 -> random stays 15.
- flush during OP of TLBWI -> tlb_we=0, done=1; flush during RESP of TLBP -> resp_valid=0; reset in OP -> IDLE, no strobes next cycle.
